// File: rtl/mdu_sequencer_if.sv
// Handshake bundle between the Execute stage and the M-extension sequencer.
// master: E-stage side (start, op, operands, flush); slave: sequencer (stall, valid, result).
interface mdu_sequencer_if;
    logic        startE_i;
    logic [2:0]  funct3E_i;
    logic [31:0] SrcAE_i;
    logic [31:0] SrcBE_i;
    logic        flushE_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;

    modport master (
        output startE_i, funct3E_i, SrcAE_i, SrcBE_i, flushE_i,
        input  stall_o, valid_o, result_o
    );

    modport slave (
        input  startE_i, funct3E_i, SrcAE_i, SrcBE_i, flushE_i,
        output stall_o, valid_o, result_o
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply, restoring divide.
// Ports: clk, rst_n (async active-low), bus (slave: start/op/operands/flush in; stall/valid/result out).
module mdu_sequencer (
    input  logic              clk,
    input  logic              rst_n,
    mdu_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [2:0]  op;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] opb;
    logic [4:0]  count;
    logic        valid_q;
    logic [31:0] result_q;

    logic [2:0]  f3;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        a_sgn;
    logic        b_sgn;
    logic        sa;
    logic        sb;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div0;
    logic        ovf;
    logic [31:0] spec_res;

    assign f3    = bus.funct3E_i;
    assign src_a = bus.SrcAE_i;
    assign src_b = bus.SrcBE_i;

    // MUL is handled as unsigned: its low word is sign-independent.
    assign a_sgn = (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b110);
    assign b_sgn = (f3 == 3'b001) || (f3 == 3'b100) ||
                   (f3 == 3'b110);
    assign sa    = a_sgn & src_a[31];
    assign sb    = b_sgn & src_b[31];
    assign a_mag = sa ? (~src_a + 32'd1) : src_a;
    assign b_mag = sb ? (~src_b + 32'd1) : src_b;

    assign div0 = f3[2] && (src_b == 32'd0);
    assign ovf  = f3[2] && !f3[0] &&
                  (src_a == 32'h8000_0000) &&
                  (src_b == 32'hFFFF_FFFF);

    always_comb begin
        spec_res = 32'd0;
        if (div0)
            spec_res = f3[1] ? src_a : 32'hFFFF_FFFF;
        else
            spec_res = f3[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    assign mul_sum = {1'b0, acc[63:32]} +
                     (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    // Divide step: acc[31:0] shifts dividend bits out, quotient bits in.
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    assign shifted = {rem, acc[31]};
    assign trial   = shifted - {1'b0, opb};
    assign q_bit   = ~trial[32];
    assign rem_nxt = q_bit ? trial[31:0] : shifted[31:0];
    assign quo_nxt = {acc[30:0], q_bit};

    // Final-iteration results, sign-corrected for the DONE write.
    logic [63:0] prod_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] mul_res;
    logic [31:0] div_res;
    assign prod_s  = (a_neg ^ b_neg) ? (~mul_nxt + 64'd1) : mul_nxt;
    assign quo_s   = (a_neg ^ b_neg) ? (~quo_nxt + 32'd1) : quo_nxt;
    assign rem_s   = a_neg ? (~rem_nxt + 32'd1) : rem_nxt;
    assign mul_res = (op[1:0] == 2'b00) ? prod_s[31:0] : prod_s[63:32];
    assign div_res = op[1] ? rem_s : quo_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= 3'd0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            acc      <= 64'd0;
            rem      <= 32'd0;
            opb      <= 32'd0;
            count    <= 5'd0;
            valid_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flushE_i) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.startE_i) begin
                            op    <= f3;
                            a_neg <= sa;
                            b_neg <= sb;
                            acc   <= {32'd0, a_mag};
                            rem   <= 32'd0;
                            opb   <= b_mag;
                            count <= 5'd31;
                            if (div0 || ovf) begin
                                state    <= DONE;
                                valid_q  <= 1'b1;
                                result_q <= spec_res;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        if (op[2]) begin
                            acc <= {acc[63:32], quo_nxt};
                            rem <= rem_nxt;
                        end else begin
                            acc <= mul_nxt;
                        end
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            state    <= DONE;
                            valid_q  <= 1'b1;
                            result_q <= op[2] ? div_res : mul_res;
                        end
                    end
                    DONE: begin
                        // Finishing instruction is still in E; ignore start.
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.stall_o  = ((state == IDLE) && bus.startE_i && !bus.flushE_i) ||
                          (state == CALC);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: vector table, random ops with a
// reference model, plus flush and async-reset sequences.
module tb_mdu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if bus();

    mdu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] a32, b32;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        a32 = a;
        b32 = b;
        r = 32'd0;
        p = 64'd0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                      32'(a32 / b32);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 :
                      32'(a32 % b32);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] f,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the negedge of
    // the IDLE cycle following DONE, so calls can be chained back to back.
    task automatic run_op(input string name, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        bit got;
        bit stall_bad;
        logic [31:0] e;
        bus.funct3E_i = f;
        bus.SrcAE_i   = a;
        bus.SrcBE_i   = b;
        bus.startE_i  = 1'b1;
        exp_q.push_back(exp);
        #1;
        check({name, " stall_c0"}, 32'(bus.stall_o), 32'd1);
        @(negedge clk);
        bus.startE_i = 1'b0;
        got = 0;
        stall_bad = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (bus.valid_o) begin
                got = 1;
                check({name, " latency"}, 32'(c), 32'(lat));
                check({name, " stall_done"}, 32'(bus.stall_o), 32'd0);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s: valid with empty scoreboard", name);
                end else begin
                    e = exp_q.pop_front();
                    check({name, " result"}, bus.result_o, e);
                end
            end else begin
                if (!bus.stall_o) stall_bad = 1;
                @(negedge clk);
            end
        end
        if (!got) begin
            tests++;
            fails++;
            exp_q.delete();
            $display("FAIL %s: timeout, valid 0 expected 1", name);
        end
        check({name, " stall_calc"}, 32'(stall_bad), 32'd0);
        @(negedge clk);
        check({name, " valid_pulse"}, 32'(bus.valid_o), 32'd0);
    endtask

    vec_t vecs[15];

    initial begin
        logic [31:0] last;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        bit          seen;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[13] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[14] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};

        bus.startE_i  = 1'b0;
        bus.funct3E_i = 3'd0;
        bus.SrcAE_i   = 32'd0;
        bus.SrcBE_i   = 32'd0;
        bus.flushE_i  = 1'b0;

        #2;
        check("rst valid", 32'(bus.valid_o), 32'd0);
        check("rst result", bus.result_o, 32'd0);
        check("rst stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a,
                   vecs[i].b, vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            if (i == 5) rb = rb >> 20;
            run_op($sformatf("rnd%0d", i), rf, ra, rb,
                   model(rf, ra, rb), model_lat(rf, ra, rb));
        end

        // Flush in cycle 10 of a DIV; MUL started in cycle 12.
        last = bus.result_o;
        bus.funct3E_i = 3'd4;
        bus.SrcAE_i   = 32'hFFFF_FFF9;
        bus.SrcBE_i   = 32'd2;
        bus.startE_i  = 1'b1;
        seen = 0;
        @(negedge clk);
        bus.startE_i = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.valid_o) seen = 1;
            @(negedge clk);
        end
        bus.flushE_i = 1'b1;
        @(negedge clk);
        bus.flushE_i = 1'b0;
        if (bus.valid_o) seen = 1;
        check("flush stall_c11", 32'(bus.stall_o), 32'd0);
        check("flush result_kept", bus.result_o, last);
        @(negedge clk);
        if (bus.valid_o) seen = 1;
        check("flush no_valid", 32'(seen), 32'd0);
        run_op("post_flush_mul", 3'd0, 32'h1234_5678, 32'h10,
               32'h2345_6780, 33);

        // Async reset mid-CALC, then two back-to-back MULs.
        bus.funct3E_i = 3'd0;
        bus.SrcAE_i   = 32'd3;
        bus.SrcBE_i   = 32'd5;
        bus.startE_i  = 1'b1;
        @(negedge clk);
        bus.startE_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", 32'(bus.valid_o), 32'd0);
        check("arst result", bus.result_o, 32'd0);
        check("arst stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("b2b_mul0", 3'd0, 32'd6, 32'd7, 32'd42, 33);
        run_op("b2b_mul1", 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle multiply/divide sequencer for the RV32M extension in the pipelined core. It sits beside the Execute-stage ALU. It accepts one M-type operation from E and runs it iteratively over 32 cycles: shift-add for multiplies, restoring division for divides. While it runs, it holds a stall request that the hazard unit ORs into its PC/F/D enable and E-hold logic. It delivers a registered result with a one-cycle valid pulse, and it aborts cleanly when the control-hazard path flushes E.

## Interface
No parameters; the datapath is fixed at XLEN = 32.

- clk  input  1  — single clock; all state updates on the rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- startE_i  input  1  — E holds a valid M-type instruction (opcode 0110011, funct7 0000001).
- funct3E_i  input  3  — operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE_i  input  32  — rs1 operand, already forwarded.
- SrcBE_i  input  32  — rs2 operand, already forwarded.
- flushE_i  input  1  — E-stage flush from the control-hazard logic.
- stall_o  output  1  — freeze PC, F, D and hold E; combinational.
- valid_o  output  1  — result_o is valid this cycle; registered, one-cycle pulse.
- result_o  output  32  — operation result; registered, holds its last value.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - If startE_i=1 and flushE_i=0, latch funct3, operand magnitudes and sign flags; load count=31.
  - Special cases go IDLE→DONE directly. All other operations go to CALC.
- Special cases, resolved in IDLE and written to result in DONE:
  - Divisor zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → the dividend.
  - Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): DIV → 0x80000000, REM → 0.
- CALC: one iteration per cycle; count decrements. Leave for DONE when count=0 completes (32 iterations).
  - Multiply: 64-bit accumulator; add the multiplicand when the current multiplier bit is 1, then shift.
  - Divide: restoring; 33-bit partial remainder, one quotient bit per cycle.
- DONE:
  - valid_o=1 and result_o is updated.
  - Next state is always IDLE. startE_i is ignored in DONE, because the finishing instruction is still in E.
- Signedness of operands:
  - Both signed: MULH, DIV, REM.
  - A signed, B unsigned: MULHSU.
  - Both unsigned: MULHU, DIVU, REMU. MUL's low 32 bits are sign-independent.
- Sign correction, applied as two's complement at the DONE write:
  - Product negated iff the operand signs differ.
  - Quotient negated iff sign(A) ≠ sign(B).
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL: product[31:0]; MULH*: product[63:32].
  - DIV/DIVU: quotient; REM/REMU: remainder.
- Stall: stall_o = (IDLE & startE_i & ~flushE_i) | CALC. stall_o is 0 in DONE.
- Flush: flushE_i=1 in any state forces next state IDLE and suppresses valid_o. It has priority over start. result_o is unchanged.
- Reset:
  - Asynchronous, any state → IDLE.
  - valid_o=0, result_o=0, count=0, internal registers cleared. stall_o=0 unless startE_i is asserted.

## Timing
- Start seen in cycle 0 (IDLE, stall_o=1).
- Cycles 1–32 are CALC (stall_o=1).
- Cycle 33 is DONE: valid_o=1, stall_o=0. E captures result_o and advances.
- Total: 33 stall cycles; latency 33 from start to valid.
- Special cases: stall in cycle 0 only; DONE in cycle 1; latency 1.
- Back-to-back M ops: the next startE_i is accepted in the IDLE cycle following DONE (cycle 34). There is no dead cycle beyond DONE.
- Reset deassertion mid-operation: the FSM starts from IDLE; a pending startE_i is accepted on the first edge after release.
- valid_o is never high in two consecutive cycles.

## Test plan
- MUL 0x00000007 × 0xFFFFFFFD:
  - stall_o high for cycles 0–32.
  - Cycle 33: valid_o=1, result_o=0xFFFFFFEB; cycle 34: valid_o=0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 0x00000002 → 0xFFFFFFFD. REM of the same → 0xFFFFFFFF. DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM of the same → 0. For all four: valid_o in cycle 1, stall_o high only in cycle 0.
- flushE_i pulsed in cycle 10 of a DIV:
  - Cycle 11: IDLE, stall_o=0.
  - valid_o never asserts; result_o keeps its prior value.
  - A new MUL started in cycle 12 completes correctly in cycle 45.
- rst_n driven low asynchronously mid-CALC: valid_o=0, result_o=0 and stall_o=0 immediately. After release, two back-to-back MULs give valid_o in cycle 33 and cycle 67.
